// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Entry layout pairs each fetched word with the PC it came from.
package fetch_pkg;

  localparam int FETCH_PC_W = 16;
  localparam int INSTR_W    = 16;
  localparam int OPC_W      = 4;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } fetch_entry_t;

  function automatic logic is_halt(
    input logic [INSTR_W-1:0] w
  );
    return w[OPC_W-1:0] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries between fetch and decode.
// Pointers carry one extra wrap bit so full and empty are distinct.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(QDEPTH):0] count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t mem [QDEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          pop_fire;
  logic          full;

  assign count    = wr_ptr - rd_ptr;
  assign full     = count == CW'(QDEPTH);
  assign pop_fire = pop && (count != '0);
  assign head     = (count != '0) ? mem[rd_ptr[AW-1:0]] : '0;

  // Storage write; data needs no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; flush and reset empty the queue outright.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + CW'(push);
      rd_ptr <= rd_ptr + CW'(pop_fire);
    end
  end

  no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !flush && full && !pop)
  );

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, 1-cycle imem return, redirect and halt.
// Issue is credit-limited so a returning word always has a queue slot.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              QDEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] inflight_addr;
  logic            inflight;
  logic            halt_seen;
  logic            halted_r;

  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [CW:0]     occ;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            push;
  logic            pop;
  logic            halt_next;
  logic            halted_next;

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .head      (head),
    .count     (count)
  );

  assign imem_addr = pc;
  assign out_valid = count != '0;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign halted    = halted_r;

  // Issue credit, return push and halt-drain prediction.
  always_comb begin
    occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_req  = !rst && !redirect_valid && !halt_seen
                && (occ < (CW+1)'(QDEPTH));
    push      = !rst && inflight && !redirect_valid && !halt_seen;
    push_data = '{pc: inflight_addr, instr: imem_rdata};
    pop       = out_valid && out_ready;
    count_next  = count + CW'(push) - CW'(pop);
    halt_next   = halt_seen || (push && is_halt(imem_rdata));
    halted_next = halt_next && (count_next == '0) && !imem_req;
  end

  // PC, inflight tracking and halt state; redirect overrides all but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      halt_seen     <= 1'b0;
      halted_r      <= 1'b0;
    end else if (redirect_valid) begin
      pc            <= redirect_pc;
      inflight      <= 1'b0;
      halt_seen     <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      if (imem_req) begin
        pc            <= pc + 1'b1;
        inflight_addr <= pc;
      end
      inflight  <= imem_req;
      halt_seen <= halt_next;
      halted_r  <= halted_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus
// hand sequences for halt, redirect, PC wrap and mid-run reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halted;

  int passed = 0;
  int total  = 0;

  logic        halt_en   = 1'b0;
  logic [15:0] halt_addr = 16'h0005;

  instr_fetch_unit #(
    .PC_W     (16),
    .QDEPTH   (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'h000F;
    return {a[11:0], 4'h1};
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= memf(imem_addr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = rdy;
    cyc();
    cyc();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pc", 32'(out_pc), 0);
    chk("rst_instr", 32'(out_instr), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    rst = 1'b0;
    #1;
    chk("rel_req", 32'(imem_req), 1);
    chk("rel_addr", 32'(imem_addr), 0);
  endtask

  task automatic run_expect(input logic [15:0] start,
                            input int n, input int budget);
    logic [15:0] e;
    int got;
    e = start;
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      if (out_valid) begin
        chk("stream_pc", 32'(out_pc), 32'(e));
        chk("stream_instr", 32'(out_instr), 32'(memf(e)));
        e++;
        got++;
      end
      if (got < n) cyc();
    end
    if (got < n) chk("stream_count", 32'(got), 32'(n));
  endtask

  typedef struct {
    logic        rdy;
    logic        v;
    logic [15:0] pc;
    logic        req;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp;
    logic        got_halt;

    tbl[0]  = '{1'b1, 1'b0, 16'd0, 1'b1, 16'd1};
    tbl[1]  = '{1'b1, 1'b1, 16'd0, 1'b1, 16'd2};
    tbl[2]  = '{1'b1, 1'b1, 16'd1, 1'b1, 16'd3};
    tbl[3]  = '{1'b1, 1'b1, 16'd2, 1'b1, 16'd4};
    tbl[4]  = '{1'b0, 1'b1, 16'd2, 1'b1, 16'd5};
    tbl[5]  = '{1'b0, 1'b1, 16'd2, 1'b0, 16'd6};
    tbl[6]  = '{1'b0, 1'b1, 16'd2, 1'b0, 16'd6};
    tbl[7]  = '{1'b0, 1'b1, 16'd2, 1'b0, 16'd6};
    tbl[8]  = '{1'b0, 1'b1, 16'd2, 1'b0, 16'd6};
    tbl[9]  = '{1'b0, 1'b1, 16'd2, 1'b0, 16'd6};
    tbl[10] = '{1'b1, 1'b1, 16'd3, 1'b1, 16'd6};
    tbl[11] = '{1'b1, 1'b1, 16'd4, 1'b1, 16'd7};
    tbl[12] = '{1'b1, 1'b1, 16'd5, 1'b1, 16'd8};
    tbl[13] = '{1'b1, 1'b1, 16'd6, 1'b1, 16'd9};
    tbl[14] = '{1'b1, 1'b1, 16'd7, 1'b1, 16'd10};
    tbl[15] = '{1'b1, 1'b1, 16'd8, 1'b1, 16'd11};

    // streaming, stall to full, release
    halt_en = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin
      out_ready = tbl[i].rdy;
      cyc();
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].v));
      chk("tbl_pc", 32'(out_pc), 32'(tbl[i].v ? tbl[i].pc : 16'h0));
      chk("tbl_instr", 32'(out_instr),
          32'(tbl[i].v ? memf(tbl[i].pc) : 16'h0));
      chk("tbl_req", 32'(imem_req), 32'(tbl[i].req));
      chk("tbl_addr", 32'(imem_addr), 32'(tbl[i].addr));
    end

    // redirect with 3 queued and 1 inflight
    do_reset(1'b0);
    repeat (4) cyc();
    chk("pre_redir_valid", 32'(out_valid), 1);
    chk("pre_redir_pc", 32'(out_pc), 0);
    chk("pre_redir_req", 32'(imem_req), 0);
    out_ready = 1'b1;
    redirect_pc = 16'h0040;
    redirect_valid = 1'b1;
    #1;
    chk("redir_cycle_req", 32'(imem_req), 0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("post_redir_valid", 32'(out_valid), 0);
    chk("post_redir_req", 32'(imem_req), 1);
    chk("post_redir_addr", 32'(imem_addr), 32'h40);
    run_expect(16'h0040, 4, 12);

    // halt word at address 5
    halt_en = 1'b1;
    halt_addr = 16'h0005;
    do_reset(1'b1);
    exp = 16'h0;
    got_halt = 1'b0;
    for (int i = 0; i < 30 && !got_halt; i++) begin
      cyc();
      if (out_valid) begin
        chk("halt_pc", 32'(out_pc), 32'(exp));
        chk("halt_instr", 32'(out_instr), 32'(memf(exp)));
        chk("halt_early", 32'(halted), 0);
        if (out_pc == 16'h0005) got_halt = 1'b1;
        exp++;
      end
    end
    chk("halt_word_seen", 32'(got_halt), 1);
    chk("halt_count", 32'(exp), 6);
    cyc();
    chk("halted_set", 32'(halted), 1);
    chk("halted_valid", 32'(out_valid), 0);
    repeat (4) cyc();
    chk("halted_hold", 32'(halted), 1);
    chk("halted_req", 32'(imem_req), 0);
    chk("halted_no_w6", 32'(out_valid), 0);

    // redirect out of halt
    redirect_pc = 16'h0020;
    redirect_valid = 1'b1;
    #1;
    chk("unhalt_redir_req", 32'(imem_req), 0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("unhalt_halted", 32'(halted), 0);
    chk("unhalt_req", 32'(imem_req), 1);
    chk("unhalt_addr", 32'(imem_addr), 32'h20);
    run_expect(16'h0020, 3, 10);

    // PC wrap
    redirect_pc = 16'hFFFE;
    redirect_valid = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0", 32'(imem_addr), 32'hFFFE);
    cyc();
    chk("wrap_addr1", 32'(imem_addr), 32'hFFFF);
    cyc();
    chk("wrap_addr2", 32'(imem_addr), 32'h0000);
    chk("wrap_req2", 32'(imem_req), 1);
    run_expect(16'hFFFE, 3, 10);

    // reset mid-stream
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_pc", 32'(out_pc), 0);
    chk("mid_rst_instr", 32'(out_instr), 0);
    chk("mid_rst_req", 32'(imem_req), 0);
    chk("mid_rst_addr", 32'(imem_addr), 0);
    rst = 1'b0;
    #1;
    chk("restart_req", 32'(imem_req), 1);
    cyc();
    chk("restart_valid1", 32'(out_valid), 0);
    cyc();
    chk("restart_valid2", 32'(out_valid), 1);
    chk("restart_pc", 32'(out_pc), 0);
    run_expect(16'h0000, 3, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
